// File: rtl/rtp_result_collector.sv
// rtl/rtp_result_collector.sv - ray result sink: skid FIFO, result buffer, frame tracking

// Small synchronous FIFO that decouples the result handshake from buffer writes.
module rtp_result_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             one_left
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign one_left = (count == (PTR_W+1)'(1));
  assign pop_data = mem[rd_ptr];

  // Entry storage; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module rtp_result_collector #(
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MISS_VALUE = 32'h7F800000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_rays,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_ray_id,
  input  logic [31:0]       res_hitT,
  input  logic              res_hit,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       hit_count,
  output logic              err_range,
  output logic [63:0]       cycle_count
);
  localparam logic [ADDR_W:0] BUF_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W:0]   num_lat;
  logic [ADDR_W:0]   num_clamped;
  logic [31:0]       num_lat_w;
  logic [ADDR_W:0]   recv_cnt;
  logic [ADDR_W:0]   clr_ptr;
  logic              start_acc;
  logic              accept;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_one_left;
  logic              fifo_pop;
  logic [64:0]       fifo_rd;
  logic [31:0]       pop_id;
  logic [31:0]       pop_hitT;
  logic              pop_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       buffer [2**ADDR_W];

  assign num_clamped = (num_rays > BUF_DEPTH) ? BUF_DEPTH : num_rays;
  assign num_lat_w   = 32'(num_lat);
  assign start_acc   = start && ((state == S_IDLE) || (state == S_DONE));
  assign res_ready   = (state == S_COLLECT) && !fifo_full && (recv_cnt < num_lat);
  assign accept      = res_valid && res_ready;
  assign fifo_pop    = (state == S_COLLECT) && !fifo_empty;
  assign {pop_id, pop_hitT, pop_hit} = fifo_rd;
  assign busy        = (state == S_CLEAR) || (state == S_COLLECT);
  assign done        = (state == S_DONE);

  rtp_result_fifo #(
    .WIDTH (65),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data ({res_ray_id, res_hitT, res_hit}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .one_left  (fifo_one_left)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; COLLECT finishes on the edge that drains the last FIFO entry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (num_rays == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_ptr == num_lat - 1'b1) begin
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if ((recv_cnt == num_lat) && (fifo_empty || fifo_one_left)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame bookkeeping: latched ray count, counters and the sticky range error.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_lat     <= '0;
      recv_cnt    <= '0;
      clr_ptr     <= '0;
      hit_count   <= '0;
      err_range   <= 1'b0;
      cycle_count <= '0;
    end else if (start_acc) begin
      num_lat     <= num_clamped;
      recv_cnt    <= '0;
      clr_ptr     <= '0;
      hit_count   <= '0;
      err_range   <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (busy) begin
        cycle_count <= cycle_count + 64'd1;
      end
      if (state == S_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
      if (accept) begin
        recv_cnt <= recv_cnt + 1'b1;
        if (res_hit) begin
          hit_count <= hit_count + 32'd1;
        end
        if (res_ray_id >= num_lat_w) begin
          err_range <= 1'b1;
        end
      end
    end
  end

  // Buffer write source: clear sweep, or a popped result whose id is in range.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = MISS_VALUE;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_ptr[ADDR_W-1:0];
    end else if (fifo_pop && (pop_id < num_lat_w)) begin
      wr_en   = 1'b1;
      wr_addr = pop_id[ADDR_W-1:0];
      wr_data = pop_hit ? pop_hitT : MISS_VALUE;
    end
  end

  // Result buffer write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // Host read port; a same-cycle write is not visible until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= buffer[rd_addr];
      end
    end
  end
endmodule

// File: tb/tb_rtp_result_collector.sv
// tb/tb_rtp_result_collector.sv - self-checking bench for rtp_result_collector
module tb_rtp_result_collector;
  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] MISS   = 32'h7F800000;
  localparam int          LIMIT  = 400;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_rays;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_ray_id;
  logic [31:0]       res_hitT;
  logic              res_hit;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [31:0]       hit_count;
  logic              err_range;
  logic [63:0]       cycle_count;

  always #5 clock = ~clock;

  rtp_result_collector #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4),
    .MISS_VALUE (MISS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_rays    (num_rays),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ray_id  (res_ray_id),
    .res_hitT    (res_hitT),
    .res_hit     (res_hit),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done),
    .hit_count   (hit_count),
    .err_range   (err_range),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [31:0] id;
    logic [31:0] hitT;
    logic        hit;
  } res_t;

  typedef struct {
    logic [ADDR_W:0] n;
    logic [15:0]     hit_mask;
    int              exp_cycles;
    int              exp_hits;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  res_t        tx_q[$];
  vec_t        vecs[7];
  logic [31:0] m_mem[DEPTH];
  bit          m_known[DEPTH];
  int          m_n;
  int          m_hits;
  bit          m_err;
  int          accepted;
  int          edges;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_start(input int n_raw);
    m_n    = (n_raw > DEPTH) ? DEPTH : n_raw;
    m_hits = 0;
    m_err  = 0;
    for (int a = 0; a < m_n; a++) begin
      m_mem[a]   = MISS;
      m_known[a] = 1;
    end
  endtask

  task automatic model_accept(input res_t r);
    if (r.hit) m_hits++;
    if (r.id >= 32'(m_n)) m_err = 1;
    else m_mem[r.id[ADDR_W-1:0]] = r.hit ? r.hitT : MISS;
  endtask

  task automatic read_check(input int addr, input logic [31:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = addr[ADDR_W-1:0];
    tick();
    rd_en = 1'b0;
    check({name, "_rd_valid"}, rd_valid, 1);
    check({name, "_rd_data"}, rd_data, exp);
  endtask

  task automatic check_buffer(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      if (m_known[a]) read_check(a, m_mem[a], name);
    end
  endtask

  // Starts a frame and drives tx_q with random idle gaps until done or the bound.
  task automatic send_frame(input int n_raw, input int gap_pct, input string name);
    int idx;
    bit acc;
    num_rays = n_raw[ADDR_W:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    model_start(n_raw);
    edges    = 0;
    accepted = 0;
    idx      = 0;
    if (m_n > 0) begin
      check({name, "_busy"}, busy, 1);
      check({name, "_ready_in_clear"}, res_ready, 0);
    end else begin
      check({name, "_busy_zero"}, busy, 0);
    end
    while (!done && edges < LIMIT) begin
      if (m_n > 0 && edges == m_n) check({name, "_ready_first"}, res_ready, 1);
      if (idx < tx_q.size() && $urandom_range(99) >= gap_pct) begin
        res_valid  = 1'b1;
        res_ray_id = tx_q[idx].id;
        res_hitT   = tx_q[idx].hitT;
        res_hit    = tx_q[idx].hit;
      end else begin
        res_valid = 1'b0;
      end
      acc = res_valid && res_ready;
      tick();
      edges++;
      if (acc) begin
        model_accept(tx_q[idx]);
        idx++;
        accepted++;
        if (accepted == m_n) check({name, "_ready_drop"}, res_ready, 0);
      end
    end
    res_valid = 1'b0;
    check({name, "_done"}, done, 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_accepted"}, accepted, m_n);
    check({name, "_hit_count"}, hit_count, m_hits);
    check({name, "_err_range"}, err_range, m_err);
    check({name, "_cycle_count"}, cycle_count, edges);
  endtask

  initial begin
    int eff;
    int n;
    res_t r;
    reset      = 1'b1;
    start      = 1'b0;
    num_rays   = '0;
    res_valid  = 1'b0;
    res_ray_id = '0;
    res_hitT   = '0;
    res_hit    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
    tick();
    tick();
    check("rst_ready", res_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_err_range", err_range, 0);
    check("rst_cycle_count", cycle_count, 0);
    reset = 1'b0;
    tick();

    // Back-to-back frames: ids 0..n-1, hit per mask, misses carry a junk hitT.
    vecs[0] = '{5'd16, 16'hFFFF, 33, 16};
    vecs[1] = '{5'd4,  16'h000F, 9,  4};
    vecs[2] = '{5'd3,  16'h0005, 7,  2};
    vecs[3] = '{5'd1,  16'h0001, 3,  1};
    vecs[4] = '{5'd20, 16'h00FF, 33, 8};
    vecs[5] = '{5'd0,  16'h0000, 0,  0};
    vecs[6] = '{5'd31, 16'hAAAA, 33, 8};
    for (int v = 0; v < 7; v++) begin
      eff = (int'(vecs[v].n) > DEPTH) ? DEPTH : int'(vecs[v].n);
      tx_q.delete();
      for (int i = 0; i < eff; i++) begin
        r.id   = 32'(i);
        r.hit  = vecs[v].hit_mask[i];
        r.hitT = r.hit ? 32'h3F800000 + 32'(i) : 32'h12345678;
        tx_q.push_back(r);
      end
      send_frame(int'(vecs[v].n), 0, "vec");
      check("vec_tbl_cycles", cycle_count, vecs[v].exp_cycles);
      check("vec_tbl_hits", hit_count, vecs[v].exp_hits);
      check_buffer("vec_buf");
      if (v == 1) read_check(2, 32'h3F800002, "vec_addr2");
    end

    // Out-of-range id is flagged and dropped; in-range result still lands.
    tx_q.delete();
    tx_q.push_back('{32'd5, 32'h41200000, 1'b1});
    tx_q.push_back('{32'd1, 32'h41200000, 1'b1});
    send_frame(2, 0, "range");
    check("range_err_const", err_range, 1);
    read_check(1, 32'h41200000, "range_addr1");
    read_check(0, MISS, "range_addr0");
    check_buffer("range_buf");

    // Nine offered against eight expected: the ninth must never be taken.
    tx_q.delete();
    for (int i = 0; i < 9; i++) tx_q.push_back('{32'(i), 32'h40400000, 1'(i % 2)});
    send_frame(8, 0, "nine");
    res_valid  = 1'b1;
    res_ray_id = 32'd8;
    for (int k = 0; k < 3; k++) begin
      check("nine_ready_held_low", res_ready, 0);
      tick();
    end
    res_valid = 1'b0;
    check("nine_err_range", err_range, 0);

    // Read in the write cycle sees old data; the following read sees new data.
    num_rays = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    model_start(2);
    for (int k = 0; k < 50 && !res_ready; k++) tick();
    check("rdw_ready", res_ready, 1);
    res_valid  = 1'b1;
    res_ray_id = 32'd0;
    res_hitT   = 32'h40490FDB;
    res_hit    = 1'b1;
    tick();
    model_accept('{32'd0, 32'h40490FDB, 1'b1});
    res_valid = 1'b0;
    rd_en     = 1'b1;
    rd_addr   = '0;
    tick();
    check("rdw_old", rd_data, MISS);
    tick();
    check("rdw_new", rd_data, 32'h40490FDB);
    rd_en      = 1'b0;
    res_valid  = 1'b1;
    res_ray_id = 32'd1;
    res_hitT   = 32'h11111111;
    res_hit    = 1'b0;
    check("rdw_ready2", res_ready, 1);
    tick();
    model_accept('{32'd1, 32'h11111111, 1'b0});
    res_valid = 1'b0;
    for (int k = 0; k < 10 && !done; k++) tick();
    check("rdw_done", done, 1);
    check("rdw_hits", hit_count, m_hits);
    check_buffer("rdw_buf");

    // Reset in the middle of COLLECT, then a fresh one-ray frame.
    num_rays = 5'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && !res_ready; k++) tick();
    res_valid  = 1'b1;
    res_ray_id = 32'd0;
    res_hit    = 1'b1;
    tick();
    res_valid = 1'b0;
    reset     = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", res_ready, 0);
    check("mid_rst_hits", hit_count, 0);
    check("mid_rst_cycles", cycle_count, 0);
    reset = 1'b0;
    tick();
    for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
    tx_q.delete();
    tx_q.push_back('{32'd0, 32'h3F800000, 1'b1});
    send_frame(1, 0, "post_rst");
    check("post_rst_hits_const", hit_count, 1);
    check_buffer("post_rst_buf");

    // Random frames: gaps, misses, duplicates and out-of-range ids.
    for (int f = 0; f < 20; f++) begin
      n   = $urandom_range(20, 1);
      eff = (n > DEPTH) ? DEPTH : n;
      tx_q.delete();
      for (int i = 0; i < eff + 2; i++) begin
        case ($urandom_range(9))
          7, 8:    r.id = $urandom_range(31);
          9:       r.id = $urandom;
          default: r.id = $urandom_range(eff - 1);
        endcase
        r.hitT = $urandom;
        r.hit  = 1'($urandom_range(1));
        tx_q.push_back(r);
      end
      send_frame(n, $urandom_range(60), "rand");
      check_buffer("rand_buf");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
